// File: rtl/op_sched_arbiter_pkg.sv
// rtl/op_sched_arbiter_pkg.sv - opcode and FSM encodings for the shared op scheduler
//
// Purpose: opcode constants, FSM state encoding and a small opcode helper shared
// by the scheduler RTL and its bench.
// Ports: none (package).

package op_sched_pkg;

  localparam logic [2:0] OP_MUL = 3'd0;
  localparam logic [2:0] OP_DIV = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_LT  = 3'd5;
  localparam logic [2:0] OP_GT  = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // DIV and MOD share the iterative divider; everything else is single-pass.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/op_sched_arbiter_if.sv
// rtl/op_sched_arbiter_if.sv - request/response bundle between requesters and the scheduler
//
// Purpose: groups the per-requester request handshake, the single response
// handshake and the busy flag.
// Ports (signals):
//   req_valid/req_ready  NREQ         per-requester handshake
//   req_op               3*NREQ       opcode, requester i at [3i+:3]
//   req_a/req_b          WIDTH*NREQ   operands, requester i at [WIDTH*i+:WIDTH]
//   rsp_valid/rsp_ready  1            response handshake
//   rsp_id               $clog2(NREQ) requester being answered
//   rsp_data             2*WIDTH      result
//   rsp_dz               1            divide by zero flag
//   busy                 1            scheduler not idle
// Modports: master = requester side, slave = scheduler side.

interface op_sched_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [3*NREQ-1:0]       req_op;
  logic [WIDTH*NREQ-1:0]   req_a;
  logic [WIDTH*NREQ-1:0]   req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [2*WIDTH-1:0]      rsp_data;
  logic                    rsp_dz;
  logic                    busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_dz, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_dz, busy
  );
endinterface

// File: rtl/op_sched_arbiter_seq_divider.sv
// rtl/op_sched_arbiter_seq_divider.sv - restoring unsigned divider, one quotient bit per cycle
//
// Purpose: iterative restoring divider used for DIV/MOD.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      load pulse; a_i/b_i sampled on this edge
//   a_i, b_i     dividend, divisor
//   quo_o, rem_o quotient, remainder (valid when done_o pulses)
//   done_o       one-cycle pulse WIDTH edges after the start edge
//   dz_o         divisor was zero

module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             done_o,
  output logic             dz_o
);
  localparam int CNTW = $clog2(WIDTH + 1);

  logic             run_q, run_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // With a zero divisor every trial subtraction fits, so the quotient comes out
  // all ones and the remainder equals the dividend without any special case.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = shifted >= {1'b0, div_q};
    diff    = shifted[WIDTH-1:0] - div_q;

    run_d  = run_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    div_d  = div_q;
    dz_d   = dz_q;
    done_d = 1'b0;

    if (start_i) begin
      run_d = 1'b1;
      cnt_d = CNTW'(WIDTH);
      quo_d = a_i;
      rem_d = '0;
      div_d = b_i;
      dz_d  = (b_i == '0);
    end else if (run_q) begin
      quo_d = {quo_q[WIDTH-2:0], fits};
      rem_d = fits ? diff : shifted[WIDTH-1:0];
      cnt_d = cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end

  assign quo_o  = quo_q;
  assign rem_o  = rem_q;
  assign done_o = done_q;
  assign dz_o   = dz_q;

endmodule

// File: rtl/op_sched_arbiter.sv
// rtl/op_sched_arbiter.sv - round-robin scheduler sharing one arithmetic/compare unit
//
// Purpose: grants one of NREQ requesters round-robin, runs its op through a
// registered EXEC stage or the iterative divider, and returns the result on a
// single valid/ready response port.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   sif    op_sched_arbiter_if.slave (request/response handshakes, busy)

module op_sched_arbiter
  import op_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  op_sched_arbiter_if.slave sif
);
  localparam int IDW = $clog2(NREQ);
  localparam int RW  = 2 * WIDTH;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             exec_vld_q, exec_vld_d;
  logic [RW-1:0]    exec_q, exec_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [RW-1:0]    rsp_data_q, rsp_data_d;
  logic             rsp_dz_q, rsp_dz_d;

  logic             gnt_any;
  logic [IDW-1:0]   gnt_idx;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             accept, done;
  logic [NREQ-1:0]  ready;
  logic [RW-1:0]    a_x, b_x, alu_res;
  logic [WIDTH-1:0] sub_lo;

  logic             div_start, div_done, div_dz;
  logic [WIDTH-1:0] div_quo, div_rem;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest valid index at or after
  // rr_ptr is the one left standing.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (sif.req_valid[wrap_add(rr_ptr_q, off)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap_add(rr_ptr_q, off);
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_op = sif.req_op[3*i +: 3];
        sel_a  = sif.req_a[WIDTH*i +: WIDTH];
        sel_b  = sif.req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  assign accept    = (state_q == ST_IDLE) && gnt_any;
  assign div_start = accept && is_div_op(sel_op);

  always_comb begin
    ready = '0;
    if (accept) ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    a_x     = {{WIDTH{1'b0}}, a_q};
    b_x     = {{WIDTH{1'b0}}, b_q};
    sub_lo  = a_q - b_q;
    alu_res = '0;
    case (op_q)
      OP_MUL:  alu_res = a_x * b_x;
      OP_ADD:  alu_res = a_x + b_x;
      OP_SUB:  alu_res = {{(WIDTH-1){1'b0}}, (a_q < b_q), sub_lo};
      OP_LT:   alu_res = {{(RW-1){1'b0}}, (a_q < b_q)};
      OP_GT:   alu_res = {{(RW-1){1'b0}}, (a_q > b_q)};
      OP_EQ:   alu_res = {{(RW-1){1'b0}}, (a_q == b_q)};
      default: alu_res = '0;
    endcase
  end

  // Both paths end with the same result-register edge: EXEC spends one edge
  // computing into exec_q, the divider spends WIDTH edges iterating.
  assign done = ((state_q == ST_EXEC) && exec_vld_q) ||
                ((state_q == ST_DIV) && div_done);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_dz_d   = rsp_dz_q;
    exec_vld_d = (state_q == ST_EXEC) && !exec_vld_q;
    exec_d     = (state_q == ST_EXEC) ? alu_res : exec_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d     = sel_op;
          a_d      = sel_a;
          b_d      = sel_b;
          rsp_id_d = gnt_idx;
          rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          state_d  = is_div_op(sel_op) ? ST_DIV : ST_EXEC;
        end
      end
      ST_EXEC, ST_DIV: begin
        if (done) begin
          if (state_q == ST_DIV) begin
            rsp_data_d = {{WIDTH{1'b0}}, (op_q == OP_MOD) ? div_rem : div_quo};
            rsp_dz_d   = div_dz;
          end else begin
            rsp_data_d = exec_q;
            rsp_dz_d   = 1'b0;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (sif.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      exec_vld_q <= 1'b0;
      exec_q     <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_dz_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      exec_vld_q <= exec_vld_d;
      exec_q     <= exec_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_dz_q   <= rsp_dz_d;
    end
  end

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (div_start),
    .a_i     (sel_a),
    .b_i     (sel_b),
    .quo_o   (div_quo),
    .rem_o   (div_rem),
    .done_o  (div_done),
    .dz_o    (div_dz)
  );

  assign sif.req_ready = ready;
  assign sif.rsp_valid = (state_q == ST_RESP);
  assign sif.rsp_id    = rsp_id_q;
  assign sif.rsp_data  = rsp_data_q;
  assign sif.rsp_dz    = rsp_dz_q;
  assign sif.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_op_sched_arbiter.sv
// tb/tb_op_sched_arbiter.sv - self-checking bench for op_sched_arbiter

module tb_op_sched_arbiter;
  import op_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  op_sched_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) sif();

  op_sched_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_d;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int model_ptr = 0;

  logic [2:0]      t_op [NREQ];
  logic [7:0]      t_a  [NREQ];
  logic [7:0]      t_b  [NREQ];
  logic [NREQ-1:0] t_valid;

  int          r_id, r_lat;
  logic [15:0] r_data;
  logic        r_dz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      sif.req_op[3*i +: 3]         = t_op[i];
      sif.req_a[WIDTH*i +: WIDTH]  = t_a[i];
      sif.req_b[WIDTH*i +: WIDTH]  = t_b[i];
    end
    sif.req_valid = t_valid;
  endtask

  // Result rules written straight from the opcode definitions with integer math.
  function automatic void ref_calc(input logic [2:0] op, input int a, input int b,
                                   output logic [15:0] d, output logic dz);
    int r;
    dz = 1'b0;
    case (op)
      OP_MUL: r = a * b;
      OP_DIV: if (b == 0) begin r = 255; dz = 1'b1; end else r = a / b;
      OP_ADD: r = a + b;
      OP_SUB: r = (a >= b) ? a - b : a - b + 512;
      OP_MOD: if (b == 0) begin r = a; dz = 1'b1; end else r = a % b;
      OP_LT:  r = (a < b) ? 1 : 0;
      OP_GT:  r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    d = r[15:0];
  endfunction

  // One complete transaction starting in an IDLE cycle at a negedge.
  task automatic txn(input string tag, input int dly, input bit keep);
    int eg;
    logic [15:0] ed;
    logic edz;
    int elat;
    logic [31:0] hold;
    eg = -1;
    for (int off = 0; off < NREQ && eg < 0; off++)
      if (t_valid[(model_ptr + off) % NREQ]) eg = (model_ptr + off) % NREQ;
    if (eg < 0) begin
      $display("FAIL %s: no valid requester in stimulus", tag);
      n_bad++;
      return;
    end
    ref_calc(t_op[eg], int'(t_a[eg]), int'(t_b[eg]), ed, edz);
    elat = (t_op[eg] == OP_DIV || t_op[eg] == OP_MOD) ? WIDTH + 1 : 2;

    drive();
    #1;
    chk({tag, ":grant"}, 32'(sif.req_ready), 32'(1) << eg);
    @(posedge clk);
    @(negedge clk);
    if (!keep) begin
      t_valid = '0;
      drive();
    end
    #1;
    chk({tag, ":ready_busy"}, 32'({sif.req_ready, sif.busy}), 32'(1));
    r_lat = 0;
    while (!sif.rsp_valid && r_lat < 30) begin
      @(negedge clk);
      r_lat++;
    end
    r_id   = int'(sif.rsp_id);
    r_data = sif.rsp_data;
    r_dz   = sif.rsp_dz;
    chk({tag, ":latency"}, 32'(r_lat), 32'(elat));
    chk({tag, ":rsp_id"}, 32'(r_id), 32'(eg));
    chk({tag, ":rsp_data"}, 32'(r_data), 32'(ed));
    chk({tag, ":rsp_dz"}, 32'(r_dz), 32'(edz));

    hold = {7'd0, 1'b1, 4'd0, 2'(eg), ed, edz, 1'b0};
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk({tag, ":stall"}, {7'd0, sif.rsp_valid, sif.req_ready, sif.rsp_id, sif.rsp_data, sif.rsp_dz, 1'b0}, hold);
    end
    sif.rsp_ready = 1'b1;
    @(negedge clk);
    sif.rsp_ready = 1'b0;
    chk({tag, ":back_idle"}, 32'({sif.busy, sif.rsp_valid}), 32'(0));
    model_ptr = (eg + 1) % NREQ;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[13];
    int order[5];
    int seen;

    vecs[0]  = '{OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 2};
    vecs[1]  = '{OP_SUB, 8'd3,  8'd5,  16'h01FE, 1'b0, 2};
    vecs[2]  = '{OP_LT,  8'd3,  8'd5,  16'h0001, 1'b0, 2};
    vecs[3]  = '{OP_DIV, 8'd200, 8'd7, 16'd28,   1'b0, 9};
    vecs[4]  = '{OP_MOD, 8'd200, 8'd7, 16'd4,    1'b0, 9};
    vecs[5]  = '{OP_DIV, 8'd200, 8'd0, 16'h00FF, 1'b1, 9};
    vecs[6]  = '{OP_MOD, 8'd9,  8'd0,  16'd9,    1'b1, 9};
    vecs[7]  = '{OP_ADD, 8'hFF, 8'hFF, 16'h01FE, 1'b0, 2};
    vecs[8]  = '{OP_GT,  8'd5,  8'd3,  16'h0001, 1'b0, 2};
    vecs[9]  = '{OP_EQ,  8'd7,  8'd7,  16'h0001, 1'b0, 2};
    vecs[10] = '{OP_EQ,  8'd7,  8'd8,  16'h0000, 1'b0, 2};
    vecs[11] = '{OP_SUB, 8'd5,  8'd3,  16'h0002, 1'b0, 2};
    vecs[12] = '{OP_DIV, 8'd255, 8'd16, 16'd15,  1'b0, 9};
    order = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    sif.rsp_ready = 1'b0;
    t_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      t_op[i] = '0; t_a[i] = '0; t_b[i] = '0;
    end
    drive();
    repeat (3) @(negedge clk);
    #1;
    chk("reset:rsp_valid", 32'(sif.rsp_valid), 32'(0));
    chk("reset:busy", 32'(sif.busy), 32'(0));
    chk("reset:req_ready", 32'(sif.req_ready), 32'(0));
    chk("reset:rsp_id", 32'(sif.rsp_id), 32'(0));
    chk("reset:rsp_data", 32'(sif.rsp_data), 32'(0));
    chk("reset:rsp_dz", 32'(sif.rsp_dz), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_ptr = 0;

    // Round robin with every requester valid continuously.
    t_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      t_op[i] = OP_ADD; t_a[i] = 8'(i); t_b[i] = 8'd1;
    end
    for (int k = 0; k < 5; k++) begin
      txn("rr", 0, 1'b1);
      chk("rr:order", 32'(r_id), 32'(order[k]));
      chk("rr:sum", 32'(r_data), 32'(order[k] + 1));
    end

    // Response stalled for 5 cycles with all requesters still asking.
    txn("stall5", 5, 1'b1);
    t_valid = '0;
    drive();

    // Table of directed result vectors, rotated over requesters.
    for (int i = 0; i < 13; i++) begin
      t_valid = '0;
      t_valid[i % NREQ] = 1'b1;
      t_op[i % NREQ] = vecs[i].op;
      t_a[i % NREQ]  = vecs[i].a;
      t_b[i % NREQ]  = vecs[i].b;
      txn("vec", i % 3, 1'b0);
      chk("vec:data", 32'(r_data), 32'(vecs[i].exp_d));
      chk("vec:dz", 32'(r_dz), 32'(vecs[i].exp_dz));
      chk("vec:lat", 32'(r_lat), 32'(vecs[i].exp_lat));
    end

    // Pointer wrap: lone requester 2 while rr_ptr is 3.
    t_valid = 4'b0100;
    t_op[2] = OP_ADD; t_a[2] = 8'd10; t_b[2] = 8'd20;
    txn("wrap_pre", 0, 1'b0);
    t_valid = 4'b0100;
    txn("wrap", 0, 1'b0);
    chk("wrap:id", 32'(r_id), 32'(2));
    t_valid = '1;
    txn("wrap_post", 0, 1'b0);
    chk("wrap_post:id", 32'(r_id), 32'(3));

    // Reset three cycles into a divide.
    t_valid = 4'b0010;
    t_op[1] = OP_DIV; t_a[1] = 8'd200; t_b[1] = 8'd7;
    drive();
    #1;
    chk("rstdiv:grant", 32'(sif.req_ready), 32'(4'b0010));
    @(posedge clk);
    @(negedge clk);
    t_valid = '0;
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstdiv:state", 32'({sif.rsp_valid, sif.busy, sif.req_ready}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sif.rsp_valid || sif.busy) seen++;
    end
    chk("rstdiv:discarded", 32'(seen), 32'(0));
    model_ptr = 0;
    t_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      t_op[i] = OP_ADD; t_a[i] = 8'(i); t_b[i] = 8'd1;
    end
    txn("rstdiv_next", 0, 1'b0);
    chk("rstdiv_next:id", 32'(r_id), 32'(0));

    // Randomized traffic against the model.
    for (int it = 0; it < 80; it++) begin
      t_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        t_op[i] = 3'($urandom_range(0, 7));
        t_a[i]  = 8'($urandom);
        t_b[i]  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      end
      txn("rnd", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
